eq_coeff_bank: RTL and testbench
================================

# eq_coeff_bank

Double-buffered coefficient store and update controller for the `equalizer` biquad datapath. A host loads new A0/A1/A2/-B1/-B2 coefficients into a shadow bank and commits them. The block swaps banks atomically on a frame boundary of the equalizer input stream, so no sample is ever processed with a mix of old and new coefficients. It drives the equalizer's `eq_coeff` port directly from the active bank, replacing the bench-side coefficient ROM.

## Interface
- `NR_CHANNELS`, 3, audio channels per frame
- `NR_EQ_BANDS`, 8, biquad bands per channel
- `EQ_COEFF_WIDTH`, 32, coefficient width; format signed Q4.(W-4), so unity = 1 << (W-4)
- `NR_EQ_COEFF` (derived), NR_CHANNELS*NR_EQ_BANDS*5
- `ADDR_WIDTH` (derived), $clog2(NR_EQ_COEFF)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset: synchronous, active-low
- `wr_addr`  in  ADDR_WIDTH  shadow address: (ch*NR_EQ_BANDS+band)*5+k, with k = 0..4 for A0, A1, A2, -B1, -B2
- `wr_data`  in  EQ_COEFF_WIDTH  coefficient value
- `wr_valid` / `wr_ready`  in / out  1  write handshake
- `wr_error`  out  1  one-cycle pulse on an accepted write with wr_addr >= NR_EQ_COEFF
- `commit_valid` / `commit_ready`  in / out  1  swap request handshake
- `commit_done`  out  1  one-cycle pulse when swap and shadow resync are complete
- `s_tid`  in  $clog2(NR_CHANNELS)  snooped equalizer input id
- `s_tvalid`, `s_tready`  in  1  snooped equalizer input handshake
- `eq_coeff_addr`  in  ADDR_WIDTH  equalizer read address
- `eq_coeff`  out  EQ_COEFF_WIDTH  active-bank coefficient
- `bank_sel`  out  1  currently active bank
- `busy`  out  1  high in INIT, PENDING and COPY

## Operation
- **Storage:** two banks, each NR_EQ_COEFF words.
- **Active bank (bank_sel):** read by the equalizer, and also read by COPY.
- **Shadow bank (!bank_sel):** the only bank the host writes.
- **Frame start:** `s_tvalid & s_tready & (s_tid == 0)`. The equalizer reads coefficients only between accepting a sample and emitting it, so a swap at frame start is glitch-free.

FSM:
- **INIT** (entered from reset)
  - Counter walks addresses 0..NR_EQ_COEFF-1, one per cycle.
  - Writes unity to both banks where addr%5==0 (A0 = 1.0) and 0 elsewhere, i.e. pass-through.
  - Exits to IDLE after the last address.
- **IDLE**
  - wr_ready=1 and commit_ready=1.
  - An accepted write updates shadow[wr_addr]. An out-of-range write is dropped and pulses wr_error.
  - An accepted commit goes to PENDING.
  - Write and commit in the same cycle: the write lands first, then PENDING.
- **PENDING**
  - wr_ready=0, commit_ready=0.
  - On frame start: toggle bank_sel, go to COPY.
  - Waits indefinitely if the stream is stopped; only reset clears it.
- **COPY**
  - Counter walks 0..NR_EQ_COEFF-1, doing shadow[i] <= active[i] so the host can do partial updates.
  - After the last address: pulse commit_done, go to IDLE.
  - Frame starts during COPY are ignored.
- **Reset at any time:** returns to INIT, bank_sel=0, and re-initialises both banks. A pending commit is lost.

## Timing
- **Reset values:** eq_coeff=0, wr_ready=0, commit_ready=0, wr_error=0, commit_done=0, bank_sel=0, busy=1.
- **INIT:** lasts exactly NR_EQ_COEFF cycles (120 at defaults). wr_ready rises on the following cycle.
- **Read latency:** eq_coeff is registered; it reflects eq_coeff_addr sampled one clock earlier.
- **Swap:** bank_sel toggles on the clock edge that samples the frame-start handshake. A read address presented in that same cycle returns the old bank; any later address returns the new bank.
- **COPY:** lasts NR_EQ_COEFF cycles. commit_done pulses on the cycle after the last copy write; commit_ready is 1 again on that same cycle.
- **Write visibility:** a write is visible in the shadow bank on the next cycle. It is never visible on eq_coeff before the commit swap.

## Structure
- Package `eq_pkg` holds:
  - NR_EQ_BAND_COEFF=5 and the coefficient index constants A0..B2;
  - the state enum {INIT, IDLE, PENDING, COPY};
  - function `eq_unity(width)`, returning 1 << (width-4).
- Sub-module `eq_coeff_ram`:
  - one bank: one write port, two synchronous read ports (equalizer read and copy read);
  - instantiated twice.
- Top level holds the FSM, counters and port multiplexing.

## Test plan
- **Reset/INIT:** release rst_n, stream idle → wr_ready rises after 120 cycles; reading address 0 gives 0x1000_0000, address 1 gives 0, address 5 gives 0x1000_0000.
- **Atomic swap:** write addr 0 = 0x1800_0000 (A0 = 1.5), commit while 3-channel frames stream → bank_sel toggles only at an s_tid==0 handshake. Every frame uses all-old or all-new values; commit_done follows 120 cycles later.
- **Partial update persistence:** after the previous commit, write only addr 5 = 0x0800_0000 and commit → new bank holds addr 0 = 0x1800_0000 and addr 5 = 0x0800_0000.
- **Backpressure and errors:**
  - Writes attempted during PENDING/COPY → wr_ready=0 throughout, no data change.
  - wr_addr=120 in IDLE → wr_error pulse, memory unchanged.
- **Stalled stream:** commit with s_tvalid=0 for 10000 cycles → state stays PENDING, bank_sel unchanged. Restart the stream → swap occurs at the first tid-0 handshake.
- **Reset mid-COPY:** assert rst_n=0 during COPY → bank_sel=0, INIT reruns, all banks back to unity.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared constants, FSM state type and helpers for the equalizer coefficient bank.
package eq_pkg;

  localparam int NR_EQ_BAND_COEFF = 5;

  localparam int A0 = 0;
  localparam int A1 = 1;
  localparam int A2 = 2;
  localparam int B1 = 3;
  localparam int B2 = 4;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    PENDING = 2'd2,
    COPY    = 2'd3
  } eq_state_e;

  // Unity gain in signed Q4.(width-4).
  function automatic logic [63:0] eq_unity(input int width);
    return 64'd1 << (width - 4);
  endfunction

endpackage

// File: rtl/eq_coeff_ram.sv
// One coefficient bank: a single write port and two registered read ports
// (equalizer read and bank-to-bank copy read).
module eq_coeff_ram #(
  parameter int DEPTH = 120,
  parameter int AW    = 7,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] eq_raddr,
  output logic [W-1:0]  eq_rdata,
  input  logic [AW-1:0] cp_raddr,
  output logic [W-1:0]  cp_rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] eq_rdata_q, eq_rdata_d;
  logic [W-1:0] cp_rdata_q, cp_rdata_d;

  always_comb begin
    eq_rdata_d = mem_q[eq_raddr];
    cp_rdata_d = mem_q[cp_raddr];
  end

  // Array contents are not reset; the owner rewrites every word after reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eq_rdata_q <= '0;
      cp_rdata_q <= '0;
    end else begin
      eq_rdata_q <= eq_rdata_d;
      cp_rdata_q <= cp_rdata_d;
    end
  end

  assign eq_rdata = eq_rdata_q;
  assign cp_rdata = cp_rdata_q;

endmodule

// File: rtl/eq_coeff_bank.sv
// Double-buffered biquad coefficient store; swaps banks atomically at the
// first sample of an equalizer frame, then resyncs the shadow from the active bank.
//
// state   | meaning
// INIT    | writing pass-through coefficients into both banks
// IDLE    | host may write the shadow bank or request a commit
// PENDING | commit accepted, waiting for a frame start to swap
// COPY    | copying the new active bank back into the shadow bank
module eq_coeff_bank
  import eq_pkg::*;
#(
  parameter  int NR_CHANNELS    = 3,
  parameter  int NR_EQ_BANDS    = 8,
  parameter  int EQ_COEFF_WIDTH = 32,
  localparam int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int ADDR_WIDTH     = $clog2(NR_EQ_COEFF),
  localparam int TID_WIDTH      = $clog2(NR_CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [EQ_COEFF_WIDTH-1:0] wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic                      wr_error,
  input  logic                      commit_valid,
  output logic                      commit_ready,
  output logic                      commit_done,
  input  logic [TID_WIDTH-1:0]      s_tid,
  input  logic                      s_tvalid,
  input  logic                      s_tready,
  input  logic [ADDR_WIDTH-1:0]     eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
  output logic                      bank_sel,
  output logic                      busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NR_EQ_COEFF - 1);
  localparam logic [EQ_COEFF_WIDTH-1:0] UNITY = EQ_COEFF_WIDTH'(eq_unity(EQ_COEFF_WIDTH));

  eq_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
  logic                      bank_sel_q, bank_sel_d;
  logic                      rd_bank_q, rd_bank_d;
  logic                      done_q, done_d;

  logic [1:0]                bank_we;
  logic [1:0]                shadow_we;
  logic [ADDR_WIDTH-1:0]     bank_waddr;
  logic [EQ_COEFF_WIDTH-1:0] bank_wdata;
  logic [ADDR_WIDTH-1:0]     copy_raddr;
  logic [EQ_COEFF_WIDTH-1:0] eq_rdata0, eq_rdata1, cp_rdata0, cp_rdata1;
  logic [EQ_COEFF_WIDTH-1:0] copy_data;
  logic                      frame_start, wr_in_range, at_a0;

  assign frame_start = s_tvalid & s_tready & (s_tid == '0);
  assign wr_in_range = int'(wr_addr) < NR_EQ_COEFF;
  assign at_a0       = (cnt_q % ADDR_WIDTH'(NR_EQ_BAND_COEFF)) == ADDR_WIDTH'(A0);
  assign shadow_we   = bank_sel_q ? 2'b01 : 2'b10;
  assign copy_data   = bank_sel_q ? cp_rdata1 : cp_rdata0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bank_sel_d   = bank_sel_q;
    rd_bank_d    = bank_sel_q;
    done_d       = 1'b0;
    bank_we      = 2'b00;
    bank_waddr   = cnt_q;
    bank_wdata   = '0;
    wr_ready     = 1'b0;
    commit_ready = 1'b0;
    wr_error     = 1'b0;

    case (state_q)
      INIT: begin
        bank_we    = 2'b11;
        bank_wdata = at_a0 ? UNITY : '0;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
        if (wr_valid) begin
          if (wr_in_range) begin
            bank_we    = shadow_we;
            bank_waddr = wr_addr;
            bank_wdata = wr_data;
          end else begin
            wr_error = 1'b1;
          end
        end
        if (commit_valid) state_d = PENDING;
      end
      PENDING: begin
        if (frame_start) begin
          bank_sel_d = ~bank_sel_q;
          cnt_d      = '0;
          state_d    = COPY;
        end
      end
      COPY: begin
        // Copy read data was fetched one cycle ahead from address cnt_d.
        bank_we    = shadow_we;
        bank_wdata = copy_data;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    copy_raddr = cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      bank_sel_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      rd_bank_q  <= rd_bank_d;
      done_q     <= done_d;
    end
  end

  eq_coeff_ram #(.DEPTH(NR_EQ_COEFF), .AW(ADDR_WIDTH), .W(EQ_COEFF_WIDTH)) u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bank_we[0]),
    .waddr    (bank_waddr),
    .wdata    (bank_wdata),
    .eq_raddr (eq_coeff_addr),
    .eq_rdata (eq_rdata0),
    .cp_raddr (copy_raddr),
    .cp_rdata (cp_rdata0)
  );

  eq_coeff_ram #(.DEPTH(NR_EQ_COEFF), .AW(ADDR_WIDTH), .W(EQ_COEFF_WIDTH)) u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bank_we[1]),
    .waddr    (bank_waddr),
    .wdata    (bank_wdata),
    .eq_raddr (eq_coeff_addr),
    .eq_rdata (eq_rdata1),
    .cp_raddr (copy_raddr),
    .cp_rdata (cp_rdata1)
  );

  // The read mux follows the bank that was active when the address was sampled.
  assign eq_coeff    = rd_bank_q ? eq_rdata1 : eq_rdata0;
  assign bank_sel    = bank_sel_q;
  assign commit_done = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_eq_coeff_bank.sv
// Randomized bench for eq_coeff_bank against a bank-level reference model.
module tb_eq_coeff_bank;

  localparam int N     = 120;
  localparam int UNITY = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready, wr_error;
  logic        commit_valid, commit_ready, commit_done;
  logic [1:0]  s_tid;
  logic        s_tvalid, s_tready;
  logic [6:0]  eq_coeff_addr;
  logic [31:0] eq_coeff;
  logic        bank_sel, busy;

  eq_coeff_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_error      (wr_error),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_done   (commit_done),
    .s_tid         (s_tid),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .eq_coeff_addr (eq_coeff_addr),
    .eq_coeff      (eq_coeff),
    .bank_sel      (bank_sel),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: contents of both banks, which is active, and the
  // controller phase with its remaining cycle count.
  typedef enum {M_INIT, M_IDLE, M_PEND, M_COPY} mphase_e;

  logic [31:0] mdl [2][N];
  int          m_sel;
  mphase_e     m_phase;
  int          m_cc;
  bit          m_done;
  int          m_tid;
  logic [31:0] exp_rd;
  bit          rd_chk;
  bit          stream_on;
  bit          rd_fixed;
  logic [6:0]  rd_addr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mdl[0][i] = (i % 5 == 0) ? UNITY : 32'h0;
      mdl[1][i] = (i % 5 == 0) ? UNITY : 32'h0;
    end
    m_sel   = 0;
    m_phase = M_INIT;
    m_cc    = 0;
    m_done  = 1'b0;
    exp_rd  = 32'h0;
    rd_chk  = 1'b1;
  endtask

  // One clock: drive stream and read address, check outputs, advance model.
  task automatic cycle();
    bit fs;
    if (stream_on) begin
      s_tvalid = ($urandom % 4) != 0;
      s_tready = ($urandom % 4) != 0;
      s_tid    = 2'(m_tid);
    end else begin
      s_tvalid = 1'b0;
      s_tready = 1'b0;
      s_tid    = 2'(m_tid);
    end
    eq_coeff_addr = rd_fixed ? rd_addr : 7'($urandom_range(0, N - 1));
    #1;
    check_eq("bank_sel", 32'(bank_sel), 32'(m_sel));
    check_eq("busy", 32'(busy), 32'(m_phase != M_IDLE));
    check_eq("wr_ready", 32'(wr_ready), 32'(m_phase == M_IDLE));
    check_eq("commit_ready", 32'(commit_ready), 32'(m_phase == M_IDLE));
    check_eq("commit_done", 32'(commit_done), 32'(m_done));
    check_eq("wr_error", 32'(wr_error),
             32'(m_phase == M_IDLE && wr_valid && int'(wr_addr) >= N));
    if (rd_chk) check_eq("eq_coeff", eq_coeff, exp_rd);

    fs = s_tvalid && s_tready && (s_tid == 2'd0);
    if (s_tvalid && s_tready) m_tid = (m_tid + 1) % 3;
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_rd = mdl[m_sel][eq_coeff_addr];
      rd_chk = (m_phase != M_INIT);
      m_done = 1'b0;
      case (m_phase)
        M_INIT: begin
          m_cc++;
          if (m_cc == N) m_phase = M_IDLE;
        end
        M_IDLE: begin
          if (wr_valid && int'(wr_addr) < N) mdl[1 - m_sel][wr_addr] = wr_data;
          if (commit_valid) m_phase = M_PEND;
        end
        M_PEND: begin
          if (fs) begin
            m_sel = 1 - m_sel;
            for (int i = 0; i < N; i++) mdl[1 - m_sel][i] = mdl[m_sel][i];
            m_phase = M_COPY;
            m_cc    = 0;
          end
        end
        M_COPY: begin
          m_cc++;
          if (m_cc == N) begin
            m_phase = M_IDLE;
            m_done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cycle(input logic [6:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic commit_cycle();
    commit_valid = 1'b1;
    cycle();
    commit_valid = 1'b0;
  endtask

  task automatic wait_done(input bit host_noise);
    int n = 0;
    while (!commit_done && n < 20000) begin
      if (host_noise) begin
        wr_valid = 1'b1;
        wr_addr  = 7'($urandom_range(0, 127));
        wr_data  = $urandom;
      end
      cycle();
      n++;
    end
    wr_valid = 1'b0;
    check_eq("commit_done_seen", 32'(commit_done), 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!wr_ready && n < 300) begin
      cycle();
      n++;
    end
    check_eq(tag, n, N);
  endtask

  task automatic read_fixed(input logic [6:0] a, input string tag, input logic [31:0] exp);
    rd_fixed = 1'b1;
    rd_addr  = a;
    cycle();
    check_eq(tag, eq_coeff, exp);
    rd_fixed = 1'b0;
  endtask

  initial begin
    int n;
    logic old_sel;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_valid = 1'b0;
    s_tvalid = 1'b0; s_tready = 1'b0; s_tid = '0;
    eq_coeff_addr = '0;
    stream_on = 1'b0; rd_fixed = 1'b0; rd_addr = '0;
    m_tid = 0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) cycle();
    rst_n = 1'b1;

    wait_init("init_len");
    read_fixed(7'd0, "init_a0", UNITY);
    read_fixed(7'd1, "init_a1", 32'h0);
    read_fixed(7'd5, "init_a5", UNITY);
    repeat (40) cycle();

    // Swap while frames stream
    wr_cycle(7'd0, 32'h1800_0000);
    stream_on = 1'b1;
    repeat (5) cycle();
    commit_cycle();
    wait_done(1'b0);
    read_fixed(7'd0, "swap_a0", 32'h1800_0000);

    // Partial update keeps earlier values
    wr_cycle(7'd5, 32'h0800_0000);
    commit_cycle();
    wait_done(1'b0);
    read_fixed(7'd0, "part_a0", 32'h1800_0000);
    read_fixed(7'd5, "part_a5", 32'h0800_0000);

    // Out-of-range write and random host traffic
    wr_valid = 1'b1;
    wr_addr  = 7'd120;
    wr_data  = 32'hDEAD_BEEF;
    #1;
    check_eq("wr_err_pulse", 32'(wr_error), 32'd1);
    cycle();
    wr_valid = 1'b0;
    repeat (40) wr_cycle(7'($urandom_range(0, 127)), $urandom);
    commit_cycle();
    wait_done(1'b1);
    repeat (200) cycle();

    // Stalled stream holds the commit pending
    stream_on = 1'b0;
    wr_cycle(7'd10, 32'h0400_0000);
    commit_cycle();
    repeat (10000) cycle();
    stream_on = 1'b1;
    wait_done(1'b0);
    read_fixed(7'd10, "stall_a10", 32'h0400_0000);

    // Reset in the middle of COPY
    repeat (10) wr_cycle(7'($urandom_range(0, N - 1)), $urandom);
    old_sel = bank_sel;
    commit_cycle();
    n = 0;
    while (bank_sel == old_sel && n < 5000) begin
      cycle();
      n++;
    end
    check_eq("rst_swap_seen", 32'(bank_sel), 32'(!old_sel));
    repeat (40) cycle();
    rst_n = 1'b0;
    repeat (3) cycle();
    check_eq("rst_bank_sel", 32'(bank_sel), 32'd0);
    rst_n = 1'b1;
    wait_init("rst_init_len");
    read_fixed(7'd0, "rst_a0", UNITY);
    read_fixed(7'd3, "rst_a3", 32'h0);
    repeat (150) cycle();
    commit_cycle();
    wait_done(1'b0);
    read_fixed(7'd0, "rst_other_a0", UNITY);
    read_fixed(7'd10, "rst_other_a10", UNITY);
    repeat (150) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
